i2s_tx: RTL
===========

# i2s_tx

I2S transmitter directly downstream of the DAC sample-prep stage. It accepts one signed 24-bit stereo sample per `sample_valid` pulse and holds it in a one-entry buffer. It serialises each sample into a standard Philips I2S frame (two 32-bit slots, MSB first, one-bit delay after LRCLK) for the external audio DAC. BCLK and LRCLK are generated internally by dividing `clk`.

## Interface

Parameters:
- `CLK_DIV`, 4: `clk` cycles per BCLK half-period; must be ≥1.
- `DATA_WIDTH`, 24: sample width, equal to the DAC output width.
- `SLOT_WIDTH`, 32: BCLK periods per channel slot; must be ≥ `DATA_WIDTH`.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle strobe; `sample_l`/`sample_r` are valid in that cycle.
- `sample_l` in `DATA_WIDTH`: signed left sample.
- `sample_r` in `DATA_WIDTH`: signed right sample.
- `i2s_bclk` out 1: bit clock, registered.
- `i2s_lrclk` out 1: word select; 0 = left, 1 = right; registered.
- `i2s_sdata` out 1: serial data, registered.
- `frame_start` out 1: one-cycle pulse when a new frame is loaded.
- `status_clr` in 1: clears the status outputs.
- `overflow` out 1: sticky; a buffered sample was overwritten.
- `underrun` out 1: sticky; a frame was loaded with no new sample.
- `underrun_count` out 16: saturating count of underrun frames.

## Operation
- **Divider:** `div_cnt` counts 0..`CLK_DIV`-1 and wraps. `i2s_bclk` toggles in the cycle where `div_cnt`=`CLK_DIV`-1. A "fall cycle" is a toggle cycle in which `i2s_bclk` goes 1→0.
- **Bit counter:** `bit_cnt` covers 0..2·`SLOT_WIDTH`-1 (0..63). It advances only in fall cycles and wraps from 63 to 0.
- **`i2s_lrclk`** is updated in fall cycles to (new `bit_cnt` ≥ `SLOT_WIDTH`).
- **Frame word:** F = {L, zero-pad, R, zero-pad}, 64 bits, with each sample left-justified in its 32-bit slot.
- **Serial data:** in the fall cycle entering `bit_cnt`=n, `i2s_sdata` = F[64−n] for n≥1. For n=0 it is 0, which is the last padding bit of the previous frame.
- **Holding buffer:** `pend_l`, `pend_r`, `pend_full`.
  - `sample_valid` writes the buffer and sets `pend_full`.
  - If `pend_full` was already set and this is not a load cycle, the older sample is lost and `overflow` sets.
- **Load:** occurs in the fall cycle entering `bit_cnt`=0.
  - If `pend_full`: F ← buffer, `pend_full` clears, `frame_start`=1.
  - Else (underrun): F is retransmitted unchanged, `underrun` sets, `underrun_count` increments (saturating at 0xFFFF), and `frame_start` still pulses.
- **`sample_valid` in the load cycle:**
  - The load uses the buffer contents from before the cycle.
  - The new sample is written to the buffer and `pend_full` is 1 after the cycle.
  - If the buffer was empty, the frame still counts as an underrun.
  - No overflow is flagged in this case.
- **`status_clr`:** clears `overflow`, `underrun` and `underrun_count` next cycle. A same-cycle set event wins over the clear.

## Timing
- **Reset values:**
  - `i2s_bclk`=0, `i2s_lrclk`=1, `i2s_sdata`=0, `frame_start`=0.
  - Status outputs 0.
  - `div_cnt`=0, `bit_cnt`=63, F=0, `pend_full`=0.
- **After `rst_n` deasserts:**
  - First BCLK rise on the `CLK_DIV`-th clock edge.
  - First fall/load on edge 2·`CLK_DIV`.
- **Frame period:** 128·`CLK_DIV` clocks.
  - Upstream must deliver at most one sample per frame period.
  - At most one load happens per frame.
- **Latency:** `sample_valid` to that sample's MSB on `i2s_sdata` is ≤ one frame period plus 2·`CLK_DIV`+1 clocks.
- **Output edge timing:** `i2s_lrclk` and `i2s_sdata` change only in fall cycles, so the receiver samples them on BCLK rise, half a BCLK period later.
- **Reset mid-frame:** asynchronously returns every output to its reset value at once. The partial frame is discarded.

## Configuration
- `I2S_TX_STATUS_EN`
  - Defined: `overflow`, `underrun`, `underrun_count` and `status_clr` behave as above.
  - Undefined: the status registers are not built, the three outputs are tied to 0 and `status_clr` is ignored. The port list is unchanged and the serial behaviour is identical.

## Test plan
- **Reset:** with `CLK_DIV`=4, release `rst_n` → `i2s_bclk` rises at edge 4 and falls at edge 8; `frame_start` pulses at edge 8; `i2s_lrclk`=0; `i2s_sdata`=0 for the whole first frame.
- **Single frame:** send L=0x800001, R=0x7FFFFE before the first load → in the next frame, `i2s_sdata` bits 1..24 = 0x800001 MSB first and bits 33..56 = 0x7FFFFE; all padding bits are 0; `i2s_lrclk` is high for bits 32..63.
- **Underrun:** send no second sample → the following frame repeats 0x800001/0x7FFFFE; `underrun`=1, `underrun_count`=1; `status_clr` returns both to 0.
- **Overflow:** two `sample_valid` pulses 10 clocks apart within one frame → `overflow`=1 and only the second sample is transmitted.
- **Valid in load cycle:** `sample_valid` in the load cycle with an empty buffer → that frame counts as an underrun; the sample is transmitted next frame; no overflow.
- **Reset mid-frame:** assert `rst_n`=0 at `bit_cnt`=40 → all outputs return to reset values immediately; after release, the first-frame timing of the reset test repeats exactly.

Source files
------------

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S transmitter with one-entry sample buffer and internal
// BCLK/LRCLK generation from clk. Optional status block (overflow, underrun,
// underrun_count, status_clr) is built when I2S_TX_STATUS_EN is defined;
// otherwise the status outputs are tied to 0 and status_clr is ignored.
module i2s_tx #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned SLOT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample_l,
  input  logic [DATA_WIDTH-1:0] sample_r,
  output logic                  i2s_bclk,
  output logic                  i2s_lrclk,
  output logic                  i2s_sdata,
  output logic                  frame_start,
  input  logic                  status_clr,
  output logic                  overflow,
  output logic                  underrun,
  output logic [15:0]           underrun_count
);

  localparam int unsigned FW = 2 * SLOT_WIDTH;
  localparam int unsigned BW = $clog2(FW);
  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0]         div_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [FW-1:0]         frame;
  logic [DATA_WIDTH-1:0] pend_l;
  logic [DATA_WIDTH-1:0] pend_r;
  logic                  pend_full;

  logic                  tick_c;
  logic                  fall_c;
  logic                  load_c;
  logic [BW-1:0]         bit_nxt_c;
  logic [BW-1:0]         sd_idx_c;
  logic [FW-1:0]         frame_in_c;

  // Divider tick, fall-cycle detection, next bit position and load decode
  always_comb begin
    tick_c     = (div_cnt == DW'(CLK_DIV - 1));
    fall_c     = tick_c & i2s_bclk;
    bit_nxt_c  = (bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
    load_c     = fall_c & (bit_nxt_c == '0);
    // Bit n of the frame word is F[FW-n]; n=0 is gated to zero padding below
    sd_idx_c   = BW'(32'(FW) - 32'(bit_nxt_c));
    // Each sample is left-justified in its slot, remaining bits zero
    frame_in_c = (FW'(pend_l) << (FW - DATA_WIDTH)) |
                 (FW'(pend_r) << (SLOT_WIDTH - DATA_WIDTH));
  end

  // Bit clock divider, bit counter, word select and serial data shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      i2s_bclk    <= 1'b0;
      bit_cnt     <= BW'(FW - 1);
      i2s_lrclk   <= 1'b1;
      i2s_sdata   <= 1'b0;
      frame_start <= 1'b0;
      frame       <= '0;
    end else begin
      frame_start <= 1'b0;
      if (tick_c) begin
        div_cnt  <= '0;
        i2s_bclk <= ~i2s_bclk;
      end else begin
        div_cnt  <= div_cnt + DW'(1);
      end
      if (fall_c) begin
        bit_cnt   <= bit_nxt_c;
        i2s_lrclk <= (32'(bit_nxt_c) >= SLOT_WIDTH);
        if (load_c) begin
          // Last padding bit of the previous frame goes out while loading
          i2s_sdata   <= 1'b0;
          frame_start <= 1'b1;
          if (pend_full) begin
            frame <= frame_in_c;
          end
        end else begin
          i2s_sdata <= frame[sd_idx_c];
        end
      end
    end
  end

  // One-entry holding buffer; a write in the load cycle refills it after the load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_l    <= '0;
      pend_r    <= '0;
      pend_full <= 1'b0;
    end else begin
      if (sample_valid) begin
        pend_l    <= sample_l;
        pend_r    <= sample_r;
        pend_full <= 1'b1;
      end else if (load_c) begin
        pend_full <= 1'b0;
      end
    end
  end

`ifdef I2S_TX_STATUS_EN
  logic underrun_c;
  logic overflow_c;

  // Status event decode
  always_comb begin
    underrun_c = load_c & ~pend_full;
    overflow_c = sample_valid & pend_full & ~load_c;
  end

  // Sticky status flags and saturating underrun counter; set beats clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow       <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= '0;
    end else begin
      if (overflow_c) begin
        overflow <= 1'b1;
      end else if (status_clr) begin
        overflow <= 1'b0;
      end
      if (underrun_c) begin
        underrun <= 1'b1;
        if (underrun_count != 16'hFFFF) begin
          underrun_count <= underrun_count + 16'd1;
        end
      end else if (status_clr) begin
        underrun       <= 1'b0;
        underrun_count <= '0;
      end
    end
  end
`else
  logic unused_status_clr;

  assign unused_status_clr = status_clr;
  assign overflow          = 1'b0;
  assign underrun          = 1'b0;
  assign underrun_count    = '0;
`endif

endmodule
